// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC round-robin scheduler.
//   WIDTH_DEF / ANGLE_WIDTH_DEF : default engine coordinate and angle widths
//   X_INIT_DEF                  : pre-scaled CORDIC gain driven as the start X value
//   sched_state_t               : scheduler FSM states
package cordic_pkg;

    localparam int unsigned WIDTH_DEF       = 16;
    localparam int unsigned ANGLE_WIDTH_DEF = 32;
    localparam logic [15:0] X_INIT_DEF      = 16'h26DD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } sched_state_t;

endpackage

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : highest-priority index for this arbitration
//   gnt    : one-hot grant (all zero when no request)
//   gnt_id : index of the granted request
//   any    : at least one request present
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] cand;

    // Scan ptr, ptr+1, ... modulo N; the first hit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        cand   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = PW'((32'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any    = 1'b1;
                gnt_id = cand;
            end
        end
        gnt[gnt_id] = any;
    end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative CORDIC engine between NUM_REQ requesters.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   req_valid/ready     : per-requester job handshake (ready is one-hot, IDLE only)
//   req_angle           : packed angles, requester i at [i*ANGLE_WIDTH +: ANGLE_WIDTH]
//   resp_valid/ready    : one-hot result handshake back to the granted requester
//   resp_cos/sin/err    : shared result bus; err=1 means the job timed out (results 0)
//   cordic_*            : engine start pulse, start vector, angle, results and done
//   busy                : scheduler is not idle
module cordic_rr_scheduler
    import cordic_pkg::*;
#(
    parameter int unsigned          NUM_REQ        = 4,
    parameter int unsigned          WIDTH          = WIDTH_DEF,
    parameter int unsigned          ANGLE_WIDTH    = ANGLE_WIDTH_DEF,
    parameter logic [WIDTH-1:0]     X_INIT         = X_INIT_DEF,
    parameter int unsigned          TIMEOUT_CYCLES = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [WIDTH-1:0]               resp_cos,
    output logic [WIDTH-1:0]               resp_sin,
    output logic                           resp_err,
    output logic                           cordic_start,
    output logic [WIDTH-1:0]               cordic_x_start,
    output logic [WIDTH-1:0]               cordic_y_start,
    output logic [ANGLE_WIDTH-1:0]         cordic_angle,
    input  logic [WIDTH-1:0]               cordic_cosine,
    input  logic [WIDTH-1:0]               cordic_sine,
    input  logic                           cordic_done,
    output logic                           busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    sched_state_t state, state_next;

    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          grant_id;
    logic [PW-1:0]          grant_next_ptr;
    logic [TW-1:0]          timer;
    logic                   timeout_hit;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [PW-1:0]          arb_id;
    logic                   arb_any;
    logic [ANGLE_WIDTH-1:0] sel_angle;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req    (req_valid),
        .ptr    (rr_ptr),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    assign sel_angle      = req_angle[arb_id*ANGLE_WIDTH +: ANGLE_WIDTH];
    assign timeout_hit    = (timer == TW'(TIMEOUT_CYCLES - 1));
    assign grant_next_ptr = (grant_id == PW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign cordic_x_start = X_INIT;
    assign cordic_y_start = '0;
    assign busy           = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = '0;
        resp_valid   = '0;
        cordic_start = 1'b0;
        case (state)
            S_IDLE: begin
                // A granted requester is always accepted, so any valid request
                // completes its handshake this cycle.
                req_ready = arb_gnt;
                if (arb_any) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cordic_start = 1'b1;
                state_next   = S_WAIT;
            end
            S_WAIT: begin
                if (cordic_done || timeout_hit) begin
                    state_next = S_RESPOND;
                end
            end
            S_RESPOND: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            grant_id     <= '0;
            timer        <= '0;
            cordic_angle <= '0;
            resp_cos     <= '0;
            resp_sin     <= '0;
            resp_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        cordic_angle <= sel_angle;
                        grant_id     <= arb_id;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                end
                S_WAIT: begin
                    timer <= timer + 1'b1;
                    // done has priority over a coincident timeout
                    if (cordic_done) begin
                        resp_cos <= cordic_cosine;
                        resp_sin <= cordic_sine;
                        resp_err <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_cos <= '0;
                        resp_sin <= '0;
                        resp_err <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (resp_ready[grant_id]) begin
                        rr_ptr <= grant_next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Self-checking bench for cordic_rr_scheduler with a latency-programmable engine stub.
module tb_cordic_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int AW = 32;
    localparam int TO = 64;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_angle;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [W-1:0]      resp_cos;
    logic [W-1:0]      resp_sin;
    logic              resp_err;
    logic              cordic_start;
    logic [W-1:0]      cordic_x_start;
    logic [W-1:0]      cordic_y_start;
    logic [AW-1:0]     cordic_angle;
    logic [W-1:0]      cordic_cosine;
    logic [W-1:0]      cordic_sine;
    logic              cordic_done;
    logic              busy;

    int          tests = 0;
    int          fails = 0;
    int          stub_lat;
    logic [15:0] stub_cos;
    logic [15:0] stub_sin;

    cordic_rr_scheduler #(
        .NUM_REQ        (N),
        .WIDTH          (W),
        .ANGLE_WIDTH    (AW),
        .X_INIT         (16'h26DD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_angle      (req_angle),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_cos       (resp_cos),
        .resp_sin       (resp_sin),
        .resp_err       (resp_err),
        .cordic_start   (cordic_start),
        .cordic_x_start (cordic_x_start),
        .cordic_y_start (cordic_y_start),
        .cordic_angle   (cordic_angle),
        .cordic_cosine  (cordic_cosine),
        .cordic_sine    (cordic_sine),
        .cordic_done    (cordic_done),
        .busy           (busy)
    );

    assign cordic_cosine = stub_cos;
    assign cordic_sine   = stub_sin;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bounded wait expired at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_resp(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (resp_valid != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) bound_fail(name);
    endtask

    // Engine stub: done pulses stub_lat cycles after the start cycle (0 = never).
    initial begin
        int  pend;
        bit  pending;
        pend        = 0;
        pending     = 1'b0;
        cordic_done = 1'b0;
        forever begin
            @(negedge clock);
            cordic_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    pend--;
                    if (pend == 0) begin
                        cordic_done = 1'b1;
                        pending     = 1'b0;
                    end
                end
                if (cordic_start) begin
                    pending = (stub_lat > 0);
                    pend    = stub_lat;
                end
            end
        end
    end

    // Transaction-level model: a job accepted in cycle T yields its response from
    // cycle T+2+L, where L is the engine latency capped at the timeout.
    initial begin
        int           cyc;
        bit           m_idle;
        int           m_ptr, m_g, m_T, m_L;
        logic [AW-1:0] m_angle;
        logic [15:0]  m_cos, m_sin;
        logic         m_err;
        logic [N-1:0] oh;
        bit           any;
        int           g;
        cyc = 0; m_idle = 1'b1; m_ptr = 0; m_g = 0; m_T = 0; m_L = 0;
        m_angle = '0; m_cos = '0; m_sin = '0; m_err = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                m_idle  = 1'b1;
                m_ptr   = 0;
                m_angle = '0;
            end else begin
                check("m_x_start", cordic_x_start, 16'h26DD);
                check("m_y_start", cordic_y_start, 16'h0000);
                check("m_angle", cordic_angle, m_angle);
                if (m_idle) begin
                    any = 1'b0;
                    g   = 0;
                    for (int k = 0; k < N; k++) begin
                        if (!any && req_valid[(m_ptr + k) % N]) begin
                            any = 1'b1;
                            g   = (m_ptr + k) % N;
                        end
                    end
                    oh = '0;
                    if (any) oh[g] = 1'b1;
                    check("m_req_ready", req_ready, oh);
                    check("m_resp_valid_idle", resp_valid, '0);
                    check("m_start_idle", cordic_start, 1'b0);
                    check("m_busy_idle", busy, 1'b0);
                    if (any) begin
                        m_idle  = 1'b0;
                        m_g     = g;
                        m_T     = cyc;
                        m_angle = req_angle[g*AW +: AW];
                        if (stub_lat >= 1 && stub_lat <= TO) begin
                            m_L = stub_lat; m_cos = stub_cos; m_sin = stub_sin; m_err = 1'b0;
                        end else begin
                            m_L = TO; m_cos = '0; m_sin = '0; m_err = 1'b1;
                        end
                    end
                end else begin
                    check("m_req_ready_busy", req_ready, '0);
                    check("m_busy", busy, 1'b1);
                    check("m_start", cordic_start, (cyc == m_T + 1));
                    if (cyc >= m_T + 2 + m_L) begin
                        oh = '0;
                        oh[m_g] = 1'b1;
                        check("m_resp_valid", resp_valid, oh);
                        check("m_resp_cos", resp_cos, m_cos);
                        check("m_resp_sin", resp_sin, m_sin);
                        check("m_resp_err", resp_err, m_err);
                        if (resp_ready[m_g]) begin
                            m_idle = 1'b1;
                            m_ptr  = (m_g + 1) % N;
                        end
                    end else begin
                        check("m_resp_valid_wait", resp_valid, '0);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_angle  = '0;
        stub_lat   = 18;
        stub_cos   = '0;
        stub_sin   = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_resp_valid", resp_valid, 4'b0000);
        check("rst_start", cordic_start, 1'b0);
        check("rst_x_start", cordic_x_start, 16'h26DD);
        check("rst_angle", cordic_angle, 32'h0);
        check("rst_cos", resp_cos, 16'h0);

        // 1: single job, latency 18
        stub_lat   = 18;
        stub_cos   = 16'h4000;
        stub_sin   = 16'h0000;
        resp_ready = '1;
        req_valid  = 4'b0001;
        #1 check("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        check("t1_start", cordic_start, 1'b1);
        repeat (18) tick();
        check("t1_no_resp_yet", resp_valid, 4'b0000);
        tick();
        check("t1_resp_valid", resp_valid, 4'b0001);
        check("t1_resp_cos", resp_cos, 16'h4000);
        check("t1_resp_err", resp_err, 1'b0);
        tick();
        wait_idle("t1_idle");

        // 2: round-robin from rr_ptr=0
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        stub_lat  = 3;
        stub_cos  = 16'h1111;
        stub_sin  = 16'h2222;
        req_angle = {32'h4000_0003, 32'h3000_0002, 32'h2000_0001, 32'h1000_0000};
        req_valid = '1;
        for (int j = 0; j < 8; j++) begin
            wait_ready("t2_wait_ready");
            idx = -1;
            for (int b = 0; b < N; b++) if (req_ready[b]) idx = b;
            check("t2_rr_order", idx, j % N);
            tick();
        end
        req_valid = '0;
        wait_idle("t2_idle");

        // 3: response backpressure; engine output changes while held
        stub_lat   = 7;
        stub_cos   = 16'h1234;
        stub_sin   = 16'hEDCB;
        resp_ready = '0;
        req_valid  = '1;
        wait_resp("t3_wait_resp");
        check("t3_cos", resp_cos, 16'h1234);
        stub_cos = 16'hBEEF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_hold_cos", resp_cos, 16'h1234);
            check("t3_hold_sin", resp_sin, 16'hEDCB);
            check("t3_no_ready", req_ready, 4'b0000);
            check("t3_no_start", cordic_start, 1'b0);
        end
        resp_ready = '1;
        req_valid  = '0;
        tick();
        wait_idle("t3_idle");

        // 4: timeout, then a late done pulse while the response is stalled
        stub_lat   = 69;
        stub_cos   = 16'h5555;
        stub_sin   = 16'h6666;
        resp_ready = '0;
        req_valid  = 4'b0100;
        wait_ready("t4_wait_ready");
        tick();
        req_valid = '0;
        check("t4_start", cordic_start, 1'b1);
        repeat (64) tick();
        check("t4_not_yet", resp_valid, 4'b0000);
        tick();
        check("t4_resp_valid", resp_valid, 4'b0100);
        check("t4_err", resp_err, 1'b1);
        check("t4_cos", resp_cos, 16'h0000);
        check("t4_sin", resp_sin, 16'h0000);
        repeat (8) tick();
        check("t4_late_done_err", resp_err, 1'b1);
        check("t4_late_done_cos", resp_cos, 16'h0000);
        resp_ready = '1;
        tick();
        wait_idle("t4_idle");

        // 5: done on the timeout cycle
        stub_lat  = 64;
        stub_cos  = 16'h0ABC;
        stub_sin  = 16'h7FFF;
        req_valid = 4'b1000;
        wait_ready("t5_wait_ready");
        tick();
        req_valid = '0;
        repeat (65) tick();
        check("t5_resp_valid", resp_valid, 4'b1000);
        check("t5_err", resp_err, 1'b0);
        check("t5_cos", resp_cos, 16'h0ABC);
        check("t5_sin", resp_sin, 16'h7FFF);
        tick();
        wait_idle("t5_idle");

        // 6: reset during WAIT, then a normal job from rr_ptr=0
        stub_lat  = 40;
        stub_cos  = 16'h0F0F;
        req_valid = 4'b0010;
        wait_ready("t6_wait_ready");
        tick();
        req_valid = '0;
        repeat (9) tick();
        check("t6_busy_before", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_busy_after", busy, 1'b0);
        check("t6_no_resp", resp_valid, 4'b0000);
        stub_lat  = 5;
        stub_cos  = 16'h2468;
        stub_sin  = 16'h1357;
        req_valid = '1;
        wait_ready("t6_wait_ready2");
        check("t6_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        wait_resp("t6_wait_resp");
        check("t6_cos", resp_cos, 16'h2468);
        check("t6_err", resp_err, 1'b0);
        tick();
        wait_idle("t6_idle");

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
